// File: rtl/memory_pkg.sv
// Shared constants and types for the matrix-compute operand/result store.
package memory_pkg;

    localparam int DATA_W   = 8;

    localparam int A_BASE   = 0;
    localparam int B_BASE   = 16;
    localparam int AB_DEPTH = 25;

    localparam int C_SINGLE = 0;
    localparam int C_SYS3   = 4;
    localparam int C_SYS2   = 8;
    localparam int C_BANK_N = 4;
    localparam int C_DEPTH  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/memory.sv
// Operand (A/B) and result (C) register store with an init-capture FSM and
// combinational read ports toward the compute engine and the display.
module memory
    import memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init_valid_i,
    output logic              done_save_to_external,
    input  logic [DATA_W-1:0] a11, a12, a13, a14,
    input  logic [DATA_W-1:0] a21, a22, a23, a24,
    input  logic [DATA_W-1:0] a31, a32, a33, a34,
    input  logic [DATA_W-1:0] a41, a42, a43, a44,
    input  logic [DATA_W-1:0] b11, b12, b13,
    input  logic [DATA_W-1:0] b21, b22, b23,
    input  logic [DATA_W-1:0] b31, b32, b33,
    input  logic              single_valid_i,
    input  logic              sys3_valid_i,
    input  logic              sys2_valid_i,
    input  logic [DATA_W-1:0] c11, c12, c21, c22,
    input  logic [4:0]        select_from_comp,
    output logic [DATA_W-1:0] out_to_comp,
    input  logic [3:0]        select_from_display,
    output logic [DATA_W-1:0] out_to_display
);

    logic [DATA_W-1:0] ab_in     [AB_DEPTH];
    logic [DATA_W-1:0] c_in      [C_BANK_N];
    logic [DATA_W-1:0] abmem_q   [AB_DEPTH];
    logic [DATA_W-1:0] cmem_q    [C_DEPTH];
    state_e            state_q;
    logic              done_q;

    assign ab_in = '{a11, a12, a13, a14, a21, a22, a23, a24,
                     a31, a32, a33, a34, a41, a42, a43, a44,
                     b11, b12, b13, b21, b22, b23, b31, b32, b33};
    assign c_in  = '{c11, c12, c21, c22};

    // NOTE: these storage arrays are flops, not RAM macros, so they take the async reset like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            for (int i = 0; i < AB_DEPTH; i++) abmem_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (init_valid_i) state_q <= SAVE;
                end
                SAVE: begin
                    for (int i = 0; i < AB_DEPTH; i++) abmem_q[i] <= ab_in[i];
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    if (!init_valid_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result banks are written independently of the init FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < C_DEPTH; i++) cmem_q[i] <= '0;
        end else begin
            for (int i = 0; i < C_BANK_N; i++) begin
                if (single_valid_i) cmem_q[C_SINGLE + i] <= c_in[i];
                if (sys3_valid_i)   cmem_q[C_SYS3 + i]   <= c_in[i];
                if (sys2_valid_i)   cmem_q[C_SYS2 + i]   <= c_in[i];
            end
        end
    end

    assign done_save_to_external = done_q;

    assign out_to_comp    = (int'(select_from_comp) < AB_DEPTH)
                          ? abmem_q[select_from_comp] : '0;
    assign out_to_display = (int'(select_from_display) < C_DEPTH)
                          ? cmem_q[select_from_display] : '0;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: expectations are queued as stimulus is applied
// and popped when the corresponding output is sampled.
module tb_memory;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         init_valid_i = 1'b0;
    logic         done_save_to_external;
    logic [W-1:0] a [16];
    logic [W-1:0] b [9];
    logic         single_valid_i = 1'b0;
    logic         sys3_valid_i = 1'b0;
    logic         sys2_valid_i = 1'b0;
    logic [W-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic [4:0]   select_from_comp = '0;
    logic [W-1:0] out_to_comp;
    logic [3:0]   select_from_display = '0;
    logic [W-1:0] out_to_display;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    memory dut (
        .clk                   (clk),
        .rst                   (rst),
        .init_valid_i          (init_valid_i),
        .done_save_to_external (done_save_to_external),
        .a11(a[0]),  .a12(a[1]),  .a13(a[2]),  .a14(a[3]),
        .a21(a[4]),  .a22(a[5]),  .a23(a[6]),  .a24(a[7]),
        .a31(a[8]),  .a32(a[9]),  .a33(a[10]), .a34(a[11]),
        .a41(a[12]), .a42(a[13]), .a43(a[14]), .a44(a[15]),
        .b11(b[0]),  .b12(b[1]),  .b13(b[2]),
        .b21(b[3]),  .b22(b[4]),  .b23(b[5]),
        .b31(b[6]),  .b32(b[7]),  .b33(b[8]),
        .single_valid_i        (single_valid_i),
        .sys3_valid_i          (sys3_valid_i),
        .sys2_valid_i          (sys2_valid_i),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .select_from_comp      (select_from_comp),
        .out_to_comp           (out_to_comp),
        .select_from_display   (select_from_display),
        .out_to_display        (out_to_display)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pop_exp(input string tag);
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", tag);
            return 'x;
        end
        return exp_q.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_comp(input int sel, input int exp);
        select_from_comp = 5'(sel);
        exp_q.push_back(W'(exp));
        #1;
        check($sformatf("comp[%0d]", sel), out_to_comp, pop_exp("comp"));
    endtask

    task automatic read_disp(input int sel, input int exp);
        select_from_display = 4'(sel);
        exp_q.push_back(W'(exp));
        #1;
        check($sformatf("disp[%0d]", sel), out_to_display, pop_exp("disp"));
    endtask

    task automatic read_done(input string tag, input logic exp);
        exp_q.push_back(W'(exp));
        check(tag, W'(done_save_to_external), pop_exp(tag));
    endtask

    task automatic set_c(input int v0, input int v1, input int v2, input int v3);
        c11 = W'(v0); c12 = W'(v1); c21 = W'(v2); c22 = W'(v3);
    endtask

    task automatic set_ab(input int base);
        for (int i = 0; i < 16; i++) a[i] = W'(base + i);
        for (int i = 0; i < 9; i++)  b[i] = W'(base + 16 + i);
    endtask

    initial begin
        set_ab(0);
        #12 rst = 1'b1;
        tick();

        // Reset state
        read_done("done_after_reset", 1'b0);
        for (int i = 0; i < 25; i++) read_comp(i, 0);
        for (int i = 0; i < 12; i++) read_disp(i, 0);

        // Init capture: a = 1..16, b = 17..25
        set_ab(1);
        init_valid_i = 1'b1;
        tick();
        read_done("done_in_save", 1'b0);
        read_comp(0, 0);
        read_comp(24, 0);
        tick();
        read_done("done_after_capture", 1'b1);
        init_valid_i = 1'b0;
        read_comp(10, 11);
        read_comp(20, 21);
        read_comp(0, 1);
        read_comp(24, 25);
        read_comp(27, 0);
        read_done("done_held_before_drop_edge", 1'b1);
        tick();
        read_done("done_after_drop", 1'b0);
        set_ab(60);
        tick();
        tick();
        read_comp(0, 1);
        read_comp(16, 17);

        // Bank writes
        set_c(26, 27, 28, 29); single_valid_i = 1'b1;
        tick();
        single_valid_i = 1'b0;
        set_c(30, 31, 32, 33); sys3_valid_i = 1'b1;
        tick();
        sys3_valid_i = 1'b0;
        set_c(30, 31, 32, 90);
        tick();
        read_disp(7, 33);
        set_c(34, 35, 36, 37); sys2_valid_i = 1'b1;
        tick();
        sys2_valid_i = 1'b0;
        set_c(0, 0, 0, 0);
        tick();
        read_disp(0, 26);
        read_disp(3, 29);
        read_disp(6, 32);
        read_disp(7, 33);
        read_disp(11, 37);
        read_disp(14, 0);
        read_comp(5, 6);

        // Simultaneous writes
        set_c(40, 41, 42, 43);
        single_valid_i = 1'b1; sys3_valid_i = 1'b1; sys2_valid_i = 1'b1;
        read_disp(0, 26);
        tick();
        single_valid_i = 1'b0; sys3_valid_i = 1'b0; sys2_valid_i = 1'b0;
        foreach (exp_q[i]) ;
        read_disp(0, 40);
        read_disp(4, 40);
        read_disp(8, 40);
        read_disp(3, 43);
        read_disp(7, 43);
        read_disp(11, 43);

        // Reset mid-SAVE aborts the capture
        set_ab(100);
        init_valid_i = 1'b1;
        tick();
        rst = 1'b0;
        init_valid_i = 1'b0;
        #2;
        read_done("done_in_reset", 1'b0);
        rst = 1'b1;
        tick();
        tick();
        read_done("done_after_abort", 1'b0);
        read_comp(0, 0);
        read_comp(15, 0);
        read_comp(24, 0);
        read_disp(0, 0);
        read_disp(11, 0);

        // FSM back in IDLE: capture needs two edges again
        init_valid_i = 1'b1;
        tick();
        read_comp(0, 0);
        read_done("done_restart_save", 1'b0);
        tick();
        read_done("done_restart_capture", 1'b1);
        read_comp(0, 100);
        read_comp(15, 115);
        read_comp(16, 116);
        read_comp(24, 124);
        init_valid_i = 1'b0;
        tick();
        read_done("done_restart_drop", 1'b0);

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
